// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding imem read at a time, queues
// returned words with their addresses, and hands them to decode in order.
// Redirects flush the queue and kill any response still in flight.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_ir,
   output logic [31:0] id_pc
);

   localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);
   localparam logic [31:0] NOP_IR = 32'h0000_0013;

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_req_pc;
   logic             r_pending;
   logic             r_kill;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [31:0]      r_pc_q [IQ_DEPTH];
   logic [31:0]      r_ir_q [IQ_DEPTH];

   logic w_resp;
   logic w_enq;
   logic w_deq;
   logic w_room;
   logic w_req;
   logic w_unused;

   // Circular pointer advance that also handles non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(IQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Request/response qualification; the request never looks at id_ready.
   always_comb begin
      w_resp   = r_pending & imem_rvalid;
      w_enq    = w_resp & ~r_kill & ~redirect_valid;
      w_deq    = (r_count != '0) & id_ready;
      w_room   = ({1'b0, r_count} + (CNT_W+1)'(w_resp & ~r_kill))
                 < (CNT_W+1)'(IQ_DEPTH);
      w_req    = ~redirect_valid & (~r_pending | imem_rvalid) & w_room;
      w_unused = &{1'b0, redirect_pc[1:0]};
   end

   // Fetch PC, outstanding-request tracking and queue occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_pending  <= 1'b0;
         r_kill     <= 1'b0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else if (redirect_valid) begin
         // The in-flight request (if any) still owns the bus; mark it for dropping.
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_pending  <= r_pending & ~imem_rvalid;
         r_kill     <= r_pending & ~imem_rvalid;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (w_req) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_req_pc   <= r_fetch_pc;
            r_pending  <= 1'b1;
         end else if (imem_rvalid) begin
            r_pending  <= 1'b0;
         end
         if (w_resp) begin
            r_kill <= 1'b0;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_enq && w_deq) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_enq) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_deq) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
      end
   end

   // Queue storage; validity is tracked by the count, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_pc_q[r_wr_ptr] <= r_req_pc;
         r_ir_q[r_wr_ptr] <= imem_rdata;
      end
   end

   // Output decode: head of queue, or NOP/0 when empty; no request during reset.
   always_comb begin
      imem_req  = w_req & rst_n;
      imem_addr = r_fetch_pc;
      id_valid  = (r_count != '0);
      id_ir     = NOP_IR;
      id_pc     = 32'h0000_0000;
      if (id_valid) begin
         id_ir = r_ir_q[r_rd_ptr];
         id_pc = r_pc_q[r_rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory responder.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_ir;
   logic [31:0] id_pc;

   // Second instance exercising PC wraparound from a high reset address.
   logic        rst2_n;
   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        rvalid2;
   logic        id_valid2;
   logic [31:0] id_ir2;
   logic [31:0] id_pc2;

   int n_checks = 0;
   int n_errors = 0;

   int          lat = 1;
   int          cnt = 0;
   logic [31:0] raddr = '0;
   bit          inject_stray = 0;
   logic        seen2 = 0;

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_ir(id_ir), .id_pc(id_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IQ_DEPTH(4)) u_dut_wrap (
      .clk(clk), .rst_n(rst2_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_rvalid(rvalid2), .imem_rdata(32'h0000_0000),
      .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
      .id_valid(id_valid2), .id_ready(1'b1),
      .id_ir(id_ir2), .id_pc(id_pc2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents as a function of address.
   function automatic logic [31:0] instr(input logic [31:0] a);
      return {a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: answers each request 'lat' cycles later; can inject a stray response.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      rvalid2     = 1'b0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr(raddr);
            end
         end
         if (inject_stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
         end
         rvalid2 = seen2;
         #1;
         if (imem_req) begin
            cnt   = lat;
            raddr = imem_addr;
         end
         seen2 = imem_req2;
      end
   end

   // Holds reset two cycles, returns at the negedge that starts the first live cycle.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      rst2_n         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;

      // Reset values, before any clock edge
      #3;
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_ir",    id_ir,         32'h0000_0013);
      check("rst_pc",    id_pc,         32'h0000_0000);

      // Streaming with 1-cycle memory
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      rst2_n = 1'b1;
      #2;
      check("c0_req",   32'(imem_req), 32'd1);
      check("c0_addr",  imem_addr,     32'h0000_0000);
      check("w0_req",   32'(imem_req2), 32'd1);
      check("w0_addr",  imem_addr2,    32'hFFFF_FFF8);
      @(negedge clk); #2;
      check("c1_addr",  imem_addr,     32'h0000_0004);
      check("c1_valid", 32'(id_valid), 32'd0);
      check("w1_addr",  imem_addr2,    32'hFFFF_FFFC);
      @(negedge clk); #2;
      check("w2_addr",  imem_addr2,    32'h0000_0000);
      for (int k = 2; k < 8; k++) begin
         if (k > 2) begin
            @(negedge clk); #2;
         end
         check("str_valid", 32'(id_valid), 32'd1);
         check("str_pc",    id_pc,         32'(4 * (k - 2)));
         check("str_ir",    id_ir,         instr(32'(4 * (k - 2))));
         check("str_req",   32'(imem_req), 32'd1);
         check("str_addr",  imem_addr,     32'(4 * k));
      end

      // Backpressure: queue fills to 4, then drains in order
      id_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #2;
         if (c < 4) begin
            check("bp_req",  32'(imem_req), 32'd1);
            check("bp_addr", imem_addr,     32'(4 * c));
         end else begin
            check("bp_noreq", 32'(imem_req), 32'd0);
         end
         if (c >= 2) check("bp_head", id_pc, 32'h0000_0000);
         @(negedge clk);
      end
      id_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #2;
         if (j == 0) check("dr_noreq", 32'(imem_req), 32'd0);
         check("dr_valid", 32'(id_valid), 32'd1);
         check("dr_pc",    id_pc,         32'(4 * j));
         check("dr_ir",    id_ir,         instr(32'(4 * j)));
         @(negedge clk);
      end

      // Redirect while a 3-cycle request is pending
      lat = 3;
      do_reset();
      #2;
      check("rp_c0_addr", imem_addr, 32'h0000_0000);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      #2;
      check("rp_c1_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      check("rp_c2_req", 32'(imem_req), 32'd0);
      @(negedge clk); #2;
      check("rp_c3_req",   32'(imem_req), 32'd1);
      check("rp_c3_addr",  imem_addr,     32'h0000_0200);
      check("rp_c3_valid", 32'(id_valid), 32'd0);
      @(negedge clk); #2;
      check("rp_c4_valid", 32'(id_valid), 32'd0);
      @(negedge clk); #2;
      @(negedge clk); #2;
      check("rp_c6_valid", 32'(id_valid), 32'd0);
      check("rp_c6_addr",  imem_addr,     32'h0000_0204);
      @(negedge clk); #2;
      check("rp_c7_valid", 32'(id_valid), 32'd1);
      check("rp_c7_pc",    id_pc,         32'h0000_0200);
      check("rp_c7_ir",    id_ir,         instr(32'h0000_0200));

      // Misaligned redirect target, then redirect with a same-cycle response
      lat            = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      do_reset();
      #2;
      check("al_c0_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      check("al_c1_req",  32'(imem_req), 32'd1);
      check("al_c1_addr", imem_addr,     32'h0000_0100);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      #2;
      check("sc_c2_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      check("sc_c3_addr",  imem_addr,     32'h0000_0300);
      check("sc_c3_valid", 32'(id_valid), 32'd0);
      @(negedge clk); #2;
      check("sc_c4_valid", 32'(id_valid), 32'd0);
      @(negedge clk); #2;
      check("sc_c5_valid", 32'(id_valid), 32'd1);
      check("sc_c5_pc",    id_pc,         32'h0000_0300);
      check("sc_c5_ir",    id_ir,         instr(32'h0000_0300));

      // Reset mid-operation with queued entries and an outstanding request
      lat      = 3;
      id_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
      end
      #2;
      check("mr_c9_pc",   id_pc,         32'h0000_0000);
      check("mr_c9_addr", imem_addr,     32'h0000_000C);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check("mr_rst_req",   32'(imem_req), 32'd0);
      check("mr_rst_valid", 32'(id_valid), 32'd0);
      check("mr_rst_ir",    id_ir,         32'h0000_0013);
      check("mr_rst_pc",    id_pc,         32'h0000_0000);
      inject_stray = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      inject_stray = 1'b0;
      check("mr_r0_req",  32'(imem_req), 32'd1);
      check("mr_r0_addr", imem_addr,     32'h0000_0000);
      for (int r = 1; r < 4; r++) begin
         @(negedge clk); #2;
         check("mr_stale_valid", 32'(id_valid), 32'd0);
      end
      @(negedge clk); #2;
      check("mr_r4_valid", 32'(id_valid), 32'd1);
      check("mr_r4_pc",    id_pc,         32'h0000_0000);
      check("mr_r4_ir",    id_ir,         instr(32'h0000_0000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
